serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter: WIDTH, 8, operand width in bits (legal range 2..32).
REQ-002 SHALL have one clock; reset is asynchronous and active-high (ports clk and reset).
REQ-003 SHALL have port: clk  input  1  rising-edge clock.
REQ-004 SHALL have port: reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have port: start  input  1  request to add a and b; sampled only in IDLE.
REQ-006 SHALL have port: a  input  WIDTH  first operand, captured when start is accepted.
REQ-007 SHALL have port: b  input  WIDTH  second operand, captured when start is accepted.
REQ-008 SHALL have port: busy  output  1  high while in RUN.
REQ-009 SHALL have port: done  output  1  one-cycle pulse; sum/cout valid.
REQ-010 SHALL have port: sum  output  WIDTH  result a+b modulo 2^WIDTH.
REQ-011 SHALL have port: cout  output  1  carry out of bit WIDTH-1.

Function
REQ-012 SHALL implement a bit-serial adder: one full-adder slice, LSB first, one bit per clock.
REQ-013 SHALL use FSM states IDLE, RUN, DONE; IDLE->RUN on start=1; RUN->DONE when bit counter = WIDTH-1; DONE->IDLE unconditionally after one cycle.
REQ-014 SHALL, on accepting start in IDLE, load a and b into shift registers, clear carry register to 0, clear bit counter to 0.
REQ-015 SHALL, each RUN cycle, add the operand LSBs with the carry register, shift the sum bit into the result register MSB side, update carry register with slice carry, shift operands right, increment counter.
REQ-016 SHALL size the bit counter to ceil(log2(WIDTH)) bits; no wrap-around is reachable in RUN.
REQ-017 SHALL assert done exactly WIDTH+1 cycles after the clock edge that samples start=1; busy high for exactly WIDTH cycles before that.
REQ-018 SHALL drive sum and cout from registers; values valid from the done cycle and held unchanged until the next accepted start.
REQ-019 SHALL ignore start while in RUN or DONE (no queueing, operands not re-captured).
REQ-020 SHALL ignore changes on a and b except at the accepting edge.
REQ-021 SHALL accept a start asserted in the first IDLE cycle after DONE (back-to-back throughput WIDTH+2 cycles).

Reset
REQ-022 SHALL, on reset=1, immediately force state IDLE, busy=0, done=0, sum=0, cout=0, carry register=0, counter=0, operand registers=0.
REQ-023 SHALL abort any operation in progress when reset asserts mid-RUN; no done pulse is produced for the aborted operation.
REQ-024 SHALL start no operation on the first edge after reset deasserts unless start=1 is sampled then in IDLE.

Structure
REQ-025 SHALL place the FSM state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH constant in shared package serial_add_pkg.
REQ-026 SHALL instantiate exactly one sub-module fa_slice (full adder composed of two existing sum_carry half adders plus OR of carries); no other arithmetic operators in the datapath.

Verification
REQ-027 SHALL cover, WIDTH=8: a=0x00, b=0x00, start -> done after 9 cycles, sum=0x00, cout=0.
REQ-028 SHALL cover: a=0xFF, b=0x01 -> sum=0x00, cout=1 (full carry ripple).
REQ-029 SHALL cover: a=0xA5, b=0x5A -> sum=0xFF, cout=0; then immediately a=0xFF, b=0xFF -> sum=0xFE, cout=1 (back-to-back, carry register cleared between ops).
REQ-030 SHALL cover: start re-asserted with a=0x11, b=0x22 during RUN of 0x03+0x04 -> single done, sum=0x07, cout=0; second request dropped.
REQ-031 SHALL cover: reset asserted 4 cycles into RUN of 0x0F+0x01 -> busy=0, sum=0x00, cout=0 same cycle, no done pulse; new start of 0x0F+0x01 then gives sum=0x10.
REQ-032 SHALL check, every test, busy high exactly 8 cycles and done high exactly 1 cycle per accepted start.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder controller.
// Holds the FSM state encoding and the default operand width.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/fa_slice.sv
// Full adder slice built from two half adders and an OR of their carries.
// Ports: a_i, b_i operand bits; c_i carry in; s_o sum bit; c_o carry out.
module fa_slice (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic s0;
    logic c0;
    logic c1;

    sum_carry u_ha0 (
        .a_i (a_i),
        .b_i (b_i),
        .s_o (s0),
        .c_o (c0)
    );

    sum_carry u_ha1 (
        .a_i (s0),
        .b_i (c_i),
        .s_o (s_o),
        .c_o (c1)
    );

    assign c_o = c0 | c1;

endmodule

// File: rtl/sum_carry.sv
// Half adder: one-bit sum and carry of two inputs.
// Ports: a_i, b_i operands; s_o sum bit; c_o carry bit.
module sum_carry (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder slice, LSB first, one bit per clock.
// Ports: clk, reset (async high); start, a, b request; busy, done, sum, cout result.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic fa_s;
    logic fa_c;

    fa_slice u_fa (
        .a_i (a_q[0]),
        .b_i (b_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // Sum bits enter at the MSB so after WIDTH
                // shifts bit 0 holds the first (LSB) result.
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_c;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign sum  = res_q;
    // Carry register holds the final carry once RUN has finished.
    assign cout = carry_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl against a plain a+b reference.
// Directed corner cases followed by randomized operations.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int n_cmp = 0;
    int n_err = 0;
    int k;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h",
                     tag, got, exp);
        end
    endtask

    // Call at a negedge with the DUT idle; returns at the
    // negedge of the first IDLE cycle after DONE.
    task automatic run_op(input logic [W-1:0] oa,
                          input logic [W-1:0] ob,
                          input bit restart,
                          input bit scramble);
        logic [W:0]   ref_r;
        logic [W-1:0] s_at;
        logic         c_at;
        int nb;
        int nd;
        int dcyc;
        ref_r = {1'b0, oa} + {1'b0, ob};
        chk("idle_before", {busy, done}, 0);
        start = 1'b1;
        a = oa;
        b = ob;
        @(posedge clk);
        #1 start = 1'b0;
        nb = 0;
        nd = 0;
        dcyc = 0;
        s_at = '0;
        c_at = 1'b0;
        for (int cyc = 1; cyc <= W + 2; cyc++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                nd++;
                if (dcyc == 0) dcyc = cyc;
                s_at = sum;
                c_at = cout;
            end
            if (cyc == W + 2) begin
                chk("hold_sum", sum, ref_r[W-1:0]);
                chk("hold_cout", cout, ref_r[W]);
            end
            if (scramble) begin
                a = W'($urandom);
                b = W'($urandom);
            end
            if (restart && cyc == 3) begin
                start = 1'b1;
                a = W'('h11);
                b = W'('h22);
            end
            if (restart && cyc == 6) start = 1'b0;
        end
        chk("busy_cycles", nb, W);
        chk("done_pulses", nd, 1);
        chk("done_latency", dcyc, W + 1);
        chk("sum", s_at, ref_r[W-1:0]);
        chk("cout", c_at, ref_r[W]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("no_start_after_rst", busy, 0);

        run_op(W'('h00), W'('h00), 1'b0, 1'b0);
        run_op(W'('hFF), W'('h01), 1'b0, 1'b0);
        @(negedge clk);
        run_op(W'('hA5), W'('h5A), 1'b0, 1'b0);
        run_op(W'('hFF), W'('hFF), 1'b0, 1'b0);
        run_op(W'('h03), W'('h04), 1'b1, 1'b0);
        chk("restart_dropped", busy, 0);

        start = 1'b1;
        a = W'('h0F);
        b = W'('h01);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_pre_rst", busy, 1);
        reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        @(negedge clk);
        reset = 1'b0;
        k = 0;
        repeat (W + 4) begin
            @(negedge clk);
            if (done || busy) k++;
        end
        chk("no_done_after_abort", k, 0);
        run_op(W'('h0F), W'('h01), 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 3)) @(negedge clk);
            run_op(W'($urandom), W'($urandom),
                   1'b0, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
